hvac_thermostat_sequencer: RTL



---
 rtl/hvac_thermostat_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hvac_thermostat_sequencer.sv
// hvac_thermostat_sequencer
// Drives the I1..I4 command pulses of HVAC_Control from temperature, setpoint
// and a user enable. It applies a hysteresis band and enforces minimum run and
// rest times through one shared down-counter. Heat and cool are never
// switched directly; every change between them passes through IDLE.

module hvac_thermostat_sequencer #(
    parameter int TEMP_W  = 8,
    parameter int HYST    = 2,
    parameter int MIN_RUN = 16,
    parameter int MIN_OFF = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] setpoint,
    output logic              cmd_on,
    output logic              cmd_heat,
    output logic              cmd_cool,
    output logic              cmd_off,
    output logic              heating,
    output logic              cooling,
    output logic              lockout
);

    // Run and rest phases never overlap, so a single counter covers both.
    localparam int TMR_MAX = (MIN_RUN > MIN_OFF) ? MIN_RUN : MIN_OFF;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  RUN_LOAD = TMR_W'(MIN_RUN);
    localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(MIN_OFF);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [TEMP_W:0]   HYST_EXT = (TEMP_W + 1)'(HYST);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        HEAT = 2'd2,
        COOL = 2'd3
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  tmr;
    logic [TEMP_W:0]   temp_ext;
    logic [TEMP_W:0]   set_ext;
    logic              cold;
    logic              hot;
    logic              tmr_done;

    // The extra top bit keeps temp+HYST and setpoint+HYST from wrapping near full scale.
    assign temp_ext = {1'b0, temp};
    assign set_ext  = {1'b0, setpoint};
    assign cold     = (temp_ext + HYST_EXT) < set_ext;
    assign hot      = temp_ext > (set_ext + HYST_EXT);
    assign tmr_done = (tmr == '0);

    // Sequencer state, shared timer and one-cycle command pulses, all updated together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OFF;
            tmr      <= '0;
            cmd_on   <= 1'b0;
            cmd_heat <= 1'b0;
            cmd_cool <= 1'b0;
            cmd_off  <= 1'b0;
        end else begin
            cmd_on   <= 1'b0;
            cmd_heat <= 1'b0;
            cmd_cool <= 1'b0;
            cmd_off  <= 1'b0;
            tmr      <= tmr_done ? '0 : (tmr - TMR_ONE);

            case (state)
                OFF: begin
                    if (enable) begin
                        cmd_on <= 1'b1;
                        state  <= IDLE;
                    end
                end
                IDLE: begin
                    if (!enable) begin
                        cmd_off <= 1'b1;
                        state   <= OFF;
                    end else if (cold && tmr_done) begin
                        cmd_heat <= 1'b1;
                        state    <= HEAT;
                        tmr      <= RUN_LOAD;
                    end else if (hot && tmr_done) begin
                        cmd_cool <= 1'b1;
                        state    <= COOL;
                        tmr      <= RUN_LOAD;
                    end
                end
                HEAT: begin
                    if (tmr_done) begin
                        if (!enable) begin
                            cmd_off <= 1'b1;
                            state   <= OFF;
                            tmr     <= OFF_LOAD;
                        end else if (temp >= setpoint) begin
                            cmd_on <= 1'b1;
                            state  <= IDLE;
                            tmr    <= OFF_LOAD;
                        end
                    end
                end
                COOL: begin
                    if (tmr_done) begin
                        if (!enable) begin
                            cmd_off <= 1'b1;
                            state   <= OFF;
                            tmr     <= OFF_LOAD;
                        end else if (temp <= setpoint) begin
                            cmd_on <= 1'b1;
                            state  <= IDLE;
                            tmr    <= OFF_LOAD;
                        end
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

    assign heating = (state == HEAT);
    assign cooling = (state == COOL);
    assign lockout = !tmr_done;

endmodule
